// File: rtl/video_to_ram.sv
// Writes the visible pixel stream into a line ring buffer and fires a single
// start pulse so the output clock domain begins reading at a fixed line lead.
module video_to_ram #(
    parameter int unsigned H_ACTIVE      = 720,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_ACTIVE_240P = 240,
    parameter int unsigned BUFFER_LINES  = 4,
    parameter int unsigned TRIGGER_LINE  = 2,
    parameter int unsigned ADDR_WIDTH    = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            red,
    input  logic [7:0]            green,
    input  logic [7:0]            blue,
    input  logic [11:0]           counterX,
    input  logic [11:0]           counterY,
    input  logic                  line_doubler,
    input  logic                  add_line,
    input  logic                  resync,
    output logic [23:0]           wrdata,
    output logic [ADDR_WIDTH-1:0] wraddr,
    output logic                  wren,
    output logic                  starttrigger,
    output logic [11:0]           line_count
);

    localparam int unsigned AW1  = ADDR_WIDTH + 1;
    localparam int unsigned RING = H_ACTIVE * BUFFER_LINES;

    typedef enum logic {WAIT_FRAME, WRITE} state_t;

    state_t                state, state_n;
    logic [11:0]           x_prev;
    logic [ADDR_WIDTH-1:0] line_base, base_n, base_next;
    logic                  triggered, trig_n;
    logic [23:0]           data_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  wren_n, start_n;
    logic [11:0]           count_n;

    logic        pe, re, in_rows, frame_start, new_line;
    logic [11:0] ye, vl;
    logic [AW1-1:0] base_inc;

    // Decode of the incoming counters; a pixel event is any change of counterX.
    always_comb begin
        pe          = (counterX != x_prev);
        ye          = line_doubler ? {1'b0, counterY[11:1]} : counterY;
        re          = !line_doubler || !counterY[0];
        vl          = add_line ? 12'(V_ACTIVE_240P) : 12'(V_ACTIVE);
        in_rows     = re && (ye < vl);
        frame_start = pe && (counterX == 12'd0) && (counterY == 12'd0);
        new_line    = pe && (counterX == 12'd0) && in_rows && (ye != 12'd0);
        base_inc    = {1'b0, line_base} + AW1'(H_ACTIVE);
        base_next   = (base_inc >= AW1'(RING)) ? '0 : base_inc[ADDR_WIDTH-1:0];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        base_n  = line_base;
        count_n = line_count;
        trig_n  = triggered;
        data_n  = wrdata;
        addr_n  = wraddr;
        wren_n  = 1'b0;
        start_n = 1'b0;
        if (resync) begin
            state_n = WAIT_FRAME;
            trig_n  = 1'b0;
            count_n = 12'd0;
        end else if (frame_start) begin
            state_n = WRITE;
            base_n  = '0;
            count_n = 12'd1;
            wren_n  = 1'b1;
            data_n  = {red, green, blue};
            addr_n  = '0;
            start_n = (TRIGGER_LINE == 0);
            trig_n  = (TRIGGER_LINE == 0);
        end else if (state == WRITE) begin
            if (new_line) begin
                base_n  = base_next;
                count_n = (line_count == 12'hFFF) ? line_count : line_count + 12'd1;
            end
            if (pe && (counterX < 12'(H_ACTIVE)) && in_rows) begin
                wren_n = 1'b1;
                data_n = {red, green, blue};
                addr_n = base_n + ADDR_WIDTH'(counterX);
                if ((counterX == 12'd0) && (ye == 12'(TRIGGER_LINE)) && !triggered) begin
                    start_n = 1'b1;
                    trig_n  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= WAIT_FRAME;
        else       state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_prev       <= 12'hFFF;
            line_base    <= '0;
            triggered    <= 1'b0;
            wrdata       <= 24'd0;
            wraddr       <= '0;
            wren         <= 1'b0;
            starttrigger <= 1'b0;
            line_count   <= 12'd0;
        end else begin
            x_prev       <= counterX;
            line_base    <= base_n;
            triggered    <= trig_n;
            wrdata       <= data_n;
            wraddr       <= addr_n;
            wren         <= wren_n;
            starttrigger <= start_n;
            line_count   <= count_n;
        end
    end

endmodule

// File: tb/tb_video_to_ram.sv
// Randomized bench for video_to_ram against a frame/line-level reference model.
module tb_video_to_ram;

    localparam int H  = 720;
    localparam int V  = 480;
    localparam int V2 = 240;
    localparam int BL = 4;
    localparam int TL = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  red = '0, green = '0, blue = '0;
    logic [11:0] counterX = 12'hFFF, counterY = '0;
    logic        line_doubler = 1'b0, add_line = 1'b0, resync = 1'b0;
    logic [23:0] wrdata;
    logic [11:0] wraddr;
    logic        wren, starttrigger;
    logic [11:0] line_count;

    video_to_ram dut (
        .clock(clock), .reset(reset), .red(red), .green(green), .blue(blue),
        .counterX(counterX), .counterY(counterY), .line_doubler(line_doubler),
        .add_line(add_line), .resync(resync), .wrdata(wrdata), .wraddr(wraddr),
        .wren(wren), .starttrigger(starttrigger), .line_count(line_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;
    int dut_pulses = 0, mdl_pulses = 0;

    // Reference state: frame active, lines started, trigger armed, held outputs.
    bit m_active, m_trig;
    int m_lines, m_started, m_data, m_addr, m_wren, m_st, last_x;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_trig = 0; m_lines = 0; m_started = 0;
        m_data = 0; m_addr = 0; m_wren = 0; m_st = 0; last_x = 12'hFFF;
    endtask

    task automatic model_clock();
        int x  = int'(counterX);
        int y  = int'(counterY);
        bit pe = (x != last_x);
        int ye = line_doubler ? y / 2 : y;
        bit ok = (!line_doubler || (y % 2 == 0)) && (ye < (add_line ? V2 : V));
        last_x = x;
        m_wren = 0;
        m_st   = 0;
        if (resync) begin
            m_active = 0; m_trig = 0; m_lines = 0;
        end else if (pe && x == 0 && y == 0) begin
            m_active = 1; m_lines = 1; m_started = 1;
            m_wren = 1; m_addr = 0; m_data = int'({red, green, blue});
            m_st = (TL == 0); m_trig = (TL == 0);
        end else if (m_active && pe && ok) begin
            if (x == 0 && ye != 0) begin
                m_started++;
                if (m_lines < 4095) m_lines++;
            end
            if (x < H) begin
                m_wren = 1;
                m_data = int'({red, green, blue});
                m_addr = ((m_started - 1) % BL) * H + x;
                if (x == 0 && ye == TL && !m_trig) begin
                    m_st = 1; m_trig = 1;
                end
            end
        end
        mdl_pulses += m_st;
    endtask

    task automatic compare(input string tag);
        check_eq({tag, ".wren"}, 32'(wren), 32'(m_wren));
        check_eq({tag, ".start"}, 32'(starttrigger), 32'(m_st));
        check_eq({tag, ".addr"}, 32'(wraddr), 32'(m_addr));
        check_eq({tag, ".data"}, 32'(wrdata), 32'(m_data));
        check_eq({tag, ".lines"}, 32'(line_count), 32'(m_lines));
        if (starttrigger === 1'b1) dut_pulses++;
    endtask

    // One pixel period: counters change, then hold for a second clock.
    task automatic step(input int x, input int y);
        @(negedge clock);
        counterX = 12'(x);
        counterY = 12'(y);
        {red, green, blue} = 24'($urandom);
        @(posedge clock); model_clock();
        @(negedge clock); compare("pix");
        @(posedge clock); model_clock();
        @(negedge clock); compare("hold");
    endtask

    task automatic row(input int y, input int resync_at);
        int x;
        for (int i = 0; i < 6; i++) begin
            if (i == resync_at) resync = 1'b1;
            step(i, y);
        end
        x = 6 + int'($urandom_range(0, 300));
        step(x, y);
        x = x + 1 + int'($urandom_range(0, 300));
        step(x, y);
        step(719, y);
        step(720, y);
        step(721 + int'($urandom_range(0, 3000)), y);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        counterX = 12'hFFF;
        counterY = 12'd0;
        model_reset();
        #1;
        check_eq("rst.wren", 32'(wren), 32'd0);
        check_eq("rst.start", 32'(starttrigger), 32'd0);
        check_eq("rst.addr", 32'(wraddr), 32'd0);
        check_eq("rst.data", 32'(wrdata), 32'd0);
        check_eq("rst.lines", 32'(line_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge clock);
        do_reset();

        // First pixels of a frame with a fixed colour
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            counterX = 12'(i); counterY = 12'd0; {red, green, blue} = 24'h112233;
            @(posedge clock); model_clock();
            @(negedge clock);
            check_eq("p.wren", 32'(wren), 32'd1);
            check_eq("p.addr", 32'(wraddr), 32'(i));
            check_eq("p.data", 32'(wrdata), 32'h112233);
            check_eq("p.lines", 32'(line_count), 32'd1);
            @(posedge clock); model_clock();
            @(negedge clock); compare("p.hold");
        end

        // Progressive frame with ring wrap and bottom rows
        for (int y = 0; y < 6; y++) begin
            row(y, -1);
            if (y == 3) begin
                step(5, 3);
                check_eq("l3p5.addr", 32'(wraddr), 32'd2165);
            end
        end
        for (int y = 478; y <= 480; y++) row(y, -1);
        check_eq("frameA.pulses", 32'(dut_pulses), 32'd1);

        // Second frame, resync mid line 3, then recovery
        for (int y = 0; y < 3; y++) row(y, -1);
        row(3, 3);
        row(4, -1);
        resync = 1'b0;
        row(5, -1);
        for (int y = 0; y < 4; y++) row(y, -1);
        check_eq("resync.pulses", 32'(dut_pulses), 32'd3);

        // Resync coincident with frame start
        resync = 1'b1;
        step(0, 0);
        resync = 1'b0;
        step(5, 0);

        // Line-doubled frame
        line_doubler = 1'b1;
        for (int y = 0; y < 6; y++) row(y, -1);
        check_eq("dbl.lines", 32'(line_count), 32'd3);
        line_doubler = 1'b0;

        // 240p frame, row 240 is outside the stored area
        add_line = 1'b1;
        for (int y = 0; y < 4; y++) row(y, -1);
        for (int i = 0; i <= 10; i++) step(i, 240);
        row(239, -1);
        add_line = 1'b0;

        // Async reset while a write is registered
        step(0, 0);
        @(negedge clock);
        counterX = 12'd1;
        @(posedge clock);
        do_reset();
        for (int y = 0; y < 3; y++) row(y, -1);

        check_eq("pulses", 32'(dut_pulses), 32'(mdl_pulses));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_to_ram.md
Name: video_to_ram

Overview:
- Sits directly downstream of the capture/decode stage.
- Consumes the per-pixel RGB stream plus visible-area counters (counterX/counterY, line_doubler, add_line, resync).
- Writes active pixels into a dual-port line ring buffer, which the HDMI output side reads on its own clock.
- Generates a single-cycle start trigger so the output side begins reading at a fixed line lead.

Parameters:
- H_ACTIVE, 720, active pixels stored per line.
- V_ACTIVE, 480, stored lines per frame (480i/VGA).
- V_ACTIVE_240P, 240, stored lines per frame when add_line=1.
- BUFFER_LINES, 4, ring depth in lines; must be a power of two, at least 2.
- TRIGGER_LINE, 2, storage line index whose pixel 0 write fires starttrigger; must be less than BUFFER_LINES.
- ADDR_WIDTH, 12, width of wraddr; must satisfy 2^ADDR_WIDTH >= H_ACTIVE*BUFFER_LINES.

Ports:
- clock  input  1  pixel-domain clock, same clock as the capture stage.
- reset  input  1  asynchronous, active-high.
- red  input  8  pixel red component.
- green  input  8  pixel green component.
- blue  input  8  pixel blue component.
- counterX  input  12  visible-area X; advances by 1 every 2 clocks.
- counterY  input  12  visible-area Y.
- line_doubler  input  1  1 = 15 kHz source; store only even counterY, storage line = counterY>>1.
- add_line  input  1  1 = 240p/288p; frame height V_ACTIVE_240P.
- resync  input  1  1 = input timing not locked; suppress writes.
- wrdata  output  24  {red,green,blue} to RAM.
- wraddr  output  ADDR_WIDTH  RAM write address.
- wren  output  1  RAM write enable.
- starttrigger  output  1  one-cycle pulse at TRIGGER_LINE pixel 0.
- line_count  output  12  storage lines written in the current frame, saturating.

Behaviour:
- Reset: wrdata=0, wraddr=0, wren=0, starttrigger=0, line_count=0. Internal state: state=WAIT_FRAME, x_prev=12'hFFF, line_base=0, triggered=0.
- Pixel event (pe): counterX != x_prev, evaluated every clock. x_prev <= counterX every clock.
- Effective Y (ye): counterY>>1 when line_doubler=1, else counterY.
- Row eligible (re): line_doubler=0 or counterY[0]=0.
- Vertical limit (VL): V_ACTIVE_240P when add_line=1, else V_ACTIVE.
- FSM state WAIT_FRAME: wren=0. Move to WRITE when pe, counterX==0, counterY==0 and resync=0.
  - In that same cycle, the pixel (0,0) is written, line_base=0 and line_count=1.
- FSM state WRITE: on pe with counterX<H_ACTIVE, ye<VL and re=1, register the following (latency 1 clock from the counter change):
  - wren<=1, wrdata<={red,green,blue}, wraddr<=line_base+counterX.
  - Otherwise wren<=0; wrdata and wraddr hold their values.
- New storage line: pe with counterX==0, re=1, ye!=0, ye<VL, in WRITE.
  - line_base <= line_base+H_ACTIVE. When the result reaches H_ACTIVE*BUFFER_LINES it wraps to 0.
  - line_count increments, saturating at 4095.
  - The pixel-0 address uses the updated base in the same cycle; compute base_next combinationally.
- Frame end: pe with counterX==0 and counterY==0 in WRITE restarts the frame.
  - line_base=0, line_count=1, triggered=0.
  - Pixel 0 is written at address 0.
- starttrigger: set to 1 for exactly one clock, coincident with wren, for the pixel-0 write of storage line ye==TRIGGER_LINE.
  - Fires only if triggered=0; then set triggered=1.
  - At most one pulse per frame.
- resync=1, any state: next clock wren=0 and starttrigger=0, state goes to WAIT_FRAME, triggered=0, line_count=0. wrdata and wraddr hold.
- resync and frame-start coincident: resync wins; no write occurs.
- Mode change (line_doubler or add_line toggled) mid-frame: no special handling. The next frame start realigns; the VL check uses the current input values.
- Odd rows in line_doubler mode: never write and never advance line_base.
- counterX >= H_ACTIVE or ye >= VL: no write; line_base unchanged.
- Async reset mid-write: outputs drop to their reset values immediately; state returns to WAIT_FRAME.

Test Plan:
- Reset with resync=0, then drive counterY=0 and counterX stepping 0,1,2 every 2 clocks with rgb=0x112233 -> wren pulses one clock after each step; wraddr=0,1,2; wrdata=0x112233; line_count=1.
- Progressive 480 lines, BUFFER_LINES=4 -> line 3 pixel 5 gives wraddr=2165; line 4 pixel 0 gives wraddr=0 (wrap); exactly one starttrigger, at line 2 pixel 0 with wraddr=1440.
- line_doubler=1, counterY=0..5 -> writes occur only for counterY 0,2,4 at bases 0,720,1440; no wren during odd rows; line_count=3.
- add_line=1, counterY=240 with counterX=0..10 -> wren stays 0; counterX=720 on any row -> wren=0.
- resync=1 asserted mid-line 3 -> wren=0 next clock; no writes until counterX=0, counterY=0 with resync=0; then wraddr=0 and starttrigger fires again at line 2.
- Second frame after a full first frame -> starttrigger fires once per frame (two pulses total); the frame-start write has wraddr=0 and line_count=1.
